// File: rtl/fust_issue_table.sv
// Issue-side scalar FU status table: dispatch writes rows, writeback wakes them, round-robin issue to execute.
// Optional FUST_WAKEUP_BYPASS_EN: a PEND row whose last pending tag is on writeback this cycle may issue at once.
module fust_issue_table #(
    parameter int N_FU  = 3,
    parameter int FU_W  = 2,
    parameter int TAG_W = 2,
    parameter int ROW_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                disp_en,
    input  logic [FU_W-1:0]     disp_fu,
    input  logic [ROW_W-1:0]    disp_payload,
    input  logic [TAG_W-1:0]    disp_t1,
    input  logic [TAG_W-1:0]    disp_t2,
    output logic                disp_err,
    output logic [N_FU-1:0]     fust_busy,
    output logic [2*N_FU-1:0]   fust_state,
    input  logic                wb_valid,
    input  logic [TAG_W-1:0]    wb_tag,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [FU_W-1:0]     issue_fu,
    output logic [ROW_W-1:0]    issue_payload,
    input  logic [N_FU-1:0]     fu_done,
    input  logic                flush
);
    // state    | meaning
    // ST_IDLE  | row free, may be written by dispatch
    // ST_PEND  | row written, waiting on at least one producer tag
    // ST_READY | operands ready, eligible for issue
    // ST_EXEC  | issued, waiting for fu_done
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_READY = 2'd2, ST_EXEC = 2'd3} row_state_t;

    row_state_t         st_q  [N_FU];
    row_state_t         st_d  [N_FU];
    logic [TAG_W-1:0]   t1_q  [N_FU];
    logic [TAG_W-1:0]   t2_q  [N_FU];
    logic [TAG_W-1:0]   t1_d  [N_FU];
    logic [TAG_W-1:0]   t2_d  [N_FU];
    logic [ROW_W-1:0]   pl_q  [N_FU];
    logic [N_FU-1:0]    acc;
    logic [N_FU-1:0]    cand_ok;
    logic [FU_W-1:0]    rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, cand_idx;
    logic               lock_q, lock_d, err_d, cand_found, hs;

    function automatic logic [TAG_W-1:0] wb_clr(input logic [TAG_W-1:0] t, input logic v,
                                                input logic [TAG_W-1:0] wt);
        return (v && wt != '0 && t == wt) ? '0 : t;
    endfunction

    always_comb begin
        cand_ok    = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < N_FU; i++) begin
            cand_ok[i] = (st_q[i] == ST_READY);
`ifdef FUST_WAKEUP_BYPASS_EN
            if (st_q[i] == ST_PEND && wb_clr(t1_q[i], wb_valid, wb_tag) == '0 &&
                wb_clr(t2_q[i], wb_valid, wb_tag) == '0)
                cand_ok[i] = 1'b1;
`endif
        end
        // Round-robin search starting at rr_ptr
        for (int k = 0; k < N_FU; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_FU;
            if (!cand_found && cand_ok[idx]) begin
                cand_found = 1'b1;
                cand_idx   = FU_W'(idx);
            end
        end

        issue_valid   = !flush && (lock_q || cand_found);
        issue_fu      = lock_q ? lock_idx_q : cand_idx;
        issue_payload = '0;
        for (int i = 0; i < N_FU; i++)
            if (issue_fu == FU_W'(i)) issue_payload = pl_q[i];
        hs = issue_valid && issue_ready;

        acc = '0;
        for (int i = 0; i < N_FU; i++) begin
            t1_d[i] = wb_clr(t1_q[i], wb_valid, wb_tag);
            t2_d[i] = wb_clr(t2_q[i], wb_valid, wb_tag);
            st_d[i] = st_q[i];
            case (st_q[i])
                ST_PEND: if (t1_d[i] == '0 && t2_d[i] == '0) st_d[i] = ST_READY;
                ST_EXEC: if (fu_done[i]) st_d[i] = ST_IDLE;
                default: ;
            endcase
            if (hs && issue_fu == FU_W'(i)) st_d[i] = ST_EXEC;
            if (flush && (st_q[i] == ST_PEND || st_q[i] == ST_READY)) st_d[i] = ST_IDLE;
            // A row retiring this cycle may be rewritten immediately
            if (disp_en && !flush && disp_fu == FU_W'(i) &&
                (st_q[i] == ST_IDLE || (st_q[i] == ST_EXEC && fu_done[i]))) begin
                acc[i]  = 1'b1;
                t1_d[i] = wb_clr(disp_t1, wb_valid, wb_tag);
                t2_d[i] = wb_clr(disp_t2, wb_valid, wb_tag);
                st_d[i] = (t1_d[i] == '0 && t2_d[i] == '0) ? ST_READY : ST_PEND;
            end
        end
        err_d = disp_en && !flush && (acc == '0);

        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush || hs) begin
            lock_d = 1'b0;
        end else if (issue_valid && !lock_q) begin
            lock_d     = 1'b1;
            lock_idx_d = cand_idx;
        end

        rr_ptr_d = rr_ptr_q;
        if (hs) rr_ptr_d = (issue_fu == FU_W'(N_FU - 1)) ? '0 : issue_fu + 1'b1;

        for (int i = 0; i < N_FU; i++) begin
            fust_busy[i]        = (st_q[i] != ST_IDLE);
            fust_state[2*i +: 2] = st_q[i];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N_FU; i++) begin
                st_q[i] <= ST_IDLE;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
                pl_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            disp_err   <= 1'b0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                st_q[i] <= st_d[i];
                t1_q[i] <= t1_d[i];
                t2_q[i] <= t2_d[i];
                if (acc[i]) pl_q[i] <= disp_payload;
            end
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            disp_err   <= err_d;
        end
    end
endmodule

// File: tb/tb_fust_issue_table.sv
// Bench for fust_issue_table: vector table per cycle plus an issue scoreboard of {fu, payload}.
`timescale 1ns/1ps
module tb_fust_issue_table;
    localparam int I = 0, P = 1, R = 2, E = 3;

    logic        CLK = 1'b0, nRST;
    logic        disp_en, disp_err, wb_valid, issue_valid, issue_ready, flush;
    logic [1:0]  disp_fu, disp_t1, disp_t2, wb_tag, issue_fu;
    logic [31:0] disp_payload, issue_payload;
    logic [2:0]  fust_busy, fu_done;
    logic [5:0]  fust_state;

    always #5 CLK = ~CLK;

    fust_issue_table #(.N_FU(3), .FU_W(2), .TAG_W(2), .ROW_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .disp_en(disp_en), .disp_fu(disp_fu),
        .disp_payload(disp_payload), .disp_t1(disp_t1), .disp_t2(disp_t2),
        .disp_err(disp_err), .fust_busy(fust_busy), .fust_state(fust_state),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_fu(issue_fu), .issue_payload(issue_payload),
        .fu_done(fu_done), .flush(flush)
    );

    typedef struct {
        logic de; logic [1:0] dfu; logic [1:0] t1; logic [1:0] t2;
        logic wv; logic [1:0] wt; logic rdy; logic [2:0] done; logic fl;
        logic x_iv; logic [1:0] x_fu; logic [5:0] x_st; logic x_err;
    } vec_t;
    typedef struct { logic [1:0] fu; logic [31:0] pl; } iss_t;

    vec_t        vt[$];
    iss_t        sbq[$];
    logic [31:0] sb_pl[3];
    int          checks = 0, failures = 0;

    function automatic logic [5:0] S(input int s2, input int s1, input int s0);
        return {2'(s2), 2'(s1), 2'(s0)};
    endfunction

    function automatic vec_t mk(input int de, input int dfu, input int t1, input int t2,
                                input int wv, input int wt, input int rdy, input int done,
                                input int fl, input int x_iv, input int x_fu,
                                input logic [5:0] x_st, input int x_err);
        vec_t v;
        v.de = 1'(de); v.dfu = 2'(dfu); v.t1 = 2'(t1); v.t2 = 2'(t2);
        v.wv = 1'(wv); v.wt = 2'(wt); v.rdy = 1'(rdy); v.done = 3'(done); v.fl = 1'(fl);
        v.x_iv = 1'(x_iv); v.x_fu = 2'(x_fu); v.x_st = x_st; v.x_err = 1'(x_err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        disp_en = 0; disp_fu = 0; disp_t1 = 0; disp_t2 = 0; disp_payload = 0;
        wb_valid = 0; wb_tag = 0; issue_ready = 0; fu_done = 0; flush = 0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] pl;
        logic [2:0]  xb;
        pl = $urandom;
        disp_en = v.de; disp_fu = v.dfu; disp_t1 = v.t1; disp_t2 = v.t2; disp_payload = pl;
        wb_valid = v.wv; wb_tag = v.wt; issue_ready = v.rdy; fu_done = v.done; flush = v.fl;
        if (v.de && !v.fl && !v.x_err) sb_pl[v.dfu] = pl;
        if (v.x_iv && v.rdy) sbq.push_back('{v.x_fu, sb_pl[v.x_fu]});
        @(negedge CLK);
        chk($sformatf("v%0d issue_valid", idx), 32'(issue_valid), 32'(v.x_iv));
        if (v.x_iv) chk($sformatf("v%0d issue_fu", idx), 32'(issue_fu), 32'(v.x_fu));
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) xb[i] = (v.x_st[2*i +: 2] != 2'd0);
        chk($sformatf("v%0d fust_state", idx), 32'(fust_state), 32'(v.x_st));
        chk($sformatf("v%0d fust_busy", idx), 32'(fust_busy), 32'(xb));
        chk($sformatf("v%0d disp_err", idx), 32'(disp_err), 32'(v.x_err));
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_issue actual=fu%0d required=no_issue", issue_fu);
            end else begin
                iss_t e;
                e = sbq.pop_front();
                chk("sb_issue_fu", 32'(issue_fu), 32'(e.fu));
                chk("sb_issue_payload", issue_payload, e.pl);
            end
        end
    end

    initial begin
        // de dfu t1 t2 wv wt rdy done fl | iv fu state err
        vt.push_back(mk(1,1,0,0, 0,0, 1,0,0, 0,0,S(I,R,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,1,S(I,E,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b010,0, 0,0,S(I,I,I),0));
        vt.push_back(mk(1,0,2,0, 0,0, 1,0,0, 0,0,S(I,I,P),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(I,I,P),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(I,I,P),0));
`ifdef FUST_WAKEUP_BYPASS_EN
        vt.push_back(mk(0,0,0,0, 1,2, 1,0,0, 1,0,S(I,I,E),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(I,I,E),0));
`else
        vt.push_back(mk(0,0,0,0, 1,2, 1,0,0, 0,0,S(I,I,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,0,S(I,I,E),0));
`endif
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b001,0, 0,0,S(I,I,I),0));
        // fill all rows with ready ops, issue order from rr_ptr=1
        vt.push_back(mk(1,1,0,0, 0,0, 0,0,0, 0,0,S(I,R,I),0));
        vt.push_back(mk(1,2,0,0, 0,0, 0,0,0, 1,1,S(R,R,I),0));
        vt.push_back(mk(1,0,0,0, 0,0, 0,0,0, 1,1,S(R,R,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,1,S(R,E,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,2,S(E,E,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,0,S(E,E,E),0));
        // busy-row drop, then reuse with same-cycle fu_done
        vt.push_back(mk(1,2,0,0, 0,0, 1,0,0, 0,0,S(E,E,E),1));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(E,E,E),0));
        vt.push_back(mk(1,2,0,0, 0,0, 1,3'b100,0, 0,0,S(R,E,E),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,3'b011,0, 1,2,S(E,I,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b100,0, 0,0,S(I,I,I),0));
        vt.push_back(mk(1,3,0,0, 0,0, 0,0,0, 0,0,S(I,I,I),1));
        // lock holds row2 while row0 becomes READY; then flush while row0 offered
        vt.push_back(mk(1,2,0,0, 0,0, 0,0,0, 0,0,S(R,I,I),0));
        vt.push_back(mk(1,0,0,0, 0,0, 0,0,0, 1,2,S(R,I,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,0,0, 1,2,S(R,I,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,2,S(E,I,R),0));
        vt.push_back(mk(1,1,3,0, 0,0, 0,0,0, 1,0,S(E,P,R),0));
        vt.push_back(mk(1,0,0,0, 0,0, 0,0,1, 0,0,S(E,I,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(E,I,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b100,0, 0,0,S(I,I,I),0));
        // two-tag wakeup
        vt.push_back(mk(1,1,1,3, 0,0, 1,0,0, 0,0,S(I,P,I),0));
        vt.push_back(mk(0,0,0,0, 1,1, 1,0,0, 0,0,S(I,P,I),0));
`ifdef FUST_WAKEUP_BYPASS_EN
        vt.push_back(mk(0,0,0,0, 1,3, 1,0,0, 1,1,S(I,E,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 0,0,S(I,E,I),0));
`else
        vt.push_back(mk(0,0,0,0, 1,3, 1,0,0, 0,0,S(I,R,I),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,1,S(I,E,I),0));
`endif
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b010,0, 0,0,S(I,I,I),0));
        // writeback clears the incoming tag of the row being written
        vt.push_back(mk(1,0,2,0, 1,2, 1,0,0, 0,0,S(I,I,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 1,0,0, 1,0,S(I,I,E),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,3'b001,0, 0,0,S(I,I,I),0));
        // leave row0 offered (locked) for the async reset check
        vt.push_back(mk(1,0,0,0, 0,0, 0,0,0, 0,0,S(I,I,R),0));
        vt.push_back(mk(0,0,0,0, 0,0, 0,0,0, 1,0,S(I,I,R),0));

        idle_inputs();
        nRST = 1'b0;
        #12;
        chk("rst issue_valid", 32'(issue_valid), 0);
        chk("rst fust_busy", 32'(fust_busy), 0);
        chk("rst fust_state", 32'(fust_state), 0);
        chk("rst disp_err", 32'(disp_err), 0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;

        foreach (vt[n]) apply(vt[n], n);

        idle_inputs();
        #1;
        chk("t1 pre-reset issue_valid", 32'(issue_valid), 1);
        nRST = 1'b0;
        #1;
        chk("t1 async issue_valid", 32'(issue_valid), 0);
        chk("t1 async fust_busy", 32'(fust_busy), 0);
        chk("t1 async fust_state", 32'(fust_state), 0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        chk("sb queue drained", 32'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
